ddr2_read_return_buffer: RTL and testbench

- Sits between the DDR2 controller read path and the downstream read-data consumer.
- Records the address of every read command issued to the controller.
- Pairs in-order returned read data with those addresses and buffers each {adx, data} entry.
- Presents entries to the consumer through a has_return_data / get_return_data pull handshake, and throttles command issue so no returned word can ever be lost.

---
 rtl/ddr2_pkg.sv | 22 ++
 rtl/ddr2_retbuf_ram.sv | 44 ++++
 rtl/ddr2_read_return_buffer.sv | 108 ++++++++++
 tb/tb_ddr2_read_return_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// Shared types and helpers for the DDR2 read return buffer.
package ddr2_pkg;

    localparam int DDR2_DATA_W = 128;
    localparam int DDR2_ADX_W  = 27;

    // One buffered read return: the command address paired with its data word.
    typedef struct packed {
        logic [DDR2_ADX_W-1:0]  adx;
        logic [DDR2_DATA_W-1:0] data;
    } ret_entry_t;

    // Distance a - b between two wrapping pointers of aw+1 bits (aw index bits + wrap bit).
    function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/ddr2_retbuf_ram.sv
// Slot array for the read return buffer: the address field is written on
// allocate, the data field on fill, and both are read asynchronously at one
// read index. Storage is never reset.
module ddr2_retbuf_ram
    import ddr2_pkg::*;
#(
    parameter int DATA_W = DDR2_DATA_W,
    parameter int ADX_W  = DDR2_ADX_W,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              adx_we,
    input  logic [AW-1:0]     adx_waddr,
    input  logic [ADX_W-1:0]  adx_wdata,
    input  logic              data_we,
    input  logic [AW-1:0]     data_waddr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [AW-1:0]     raddr,
    output logic [ADX_W-1:0]  radx,
    output logic [DATA_W-1:0] rdata
);

    logic [ADX_W-1:0]  adx_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // Address field: captured when a read command is allocated a slot.
    always_ff @(posedge clk) begin
        if (adx_we) begin
            adx_mem[adx_waddr] <= adx_wdata;
        end
    end

    // Data field: captured when the controller returns the matching word.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_waddr] <= data_wdata;
        end
    end

    assign radx  = adx_mem[raddr];
    assign rdata = data_mem[raddr];

endmodule

// File: rtl/ddr2_read_return_buffer.sv
// DDR2 read return buffer: records read-command addresses, pairs them with
// in-order returned data, and hands {adx, data} entries to the consumer via a
// pull handshake. Command issue is throttled so a returned word always has a slot.
// Optional build macro DDR2_RETBUF_ERR_EN adds sticky err_flags[1:0]
// (bit0: dropped data word, bit1: command asserted while not ready).
module ddr2_read_return_buffer
    import ddr2_pkg::*;
#(
    parameter int DATA_W = DDR2_DATA_W,
    parameter int ADX_W  = DDR2_ADX_W,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_cmd_valid,
    input  logic [ADX_W-1:0]  rd_cmd_adx,
    output logic              rd_cmd_ready,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              has_return_data,
    input  logic              get_return_data,
    output logic [DATA_W-1:0] return_data,
    output logic [ADX_W-1:0]  return_adx
`ifdef DDR2_RETBUF_ERR_EN
    ,
    output logic [1:0]        err_flags
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       alloc_ptr;
    logic [AW:0]       fill_ptr;
    logic [AW:0]       rd_ptr;
    logic [31:0]       occupancy;
    logic              fill_pending;
    logic              alloc_fire;
    logic              fill_fire;
    logic              pop_fire;
    logic [ADX_W-1:0]  slot_adx;
    logic [DATA_W-1:0] slot_data;

    // Pending-fill and filled-unpopped slots both hold a place in the array.
    assign occupancy       = ptr_diff(32'(alloc_ptr), 32'(rd_ptr), AW);
    assign rd_cmd_ready    = occupancy < 32'(DEPTH);
    assign has_return_data = (fill_ptr != rd_ptr);
    assign fill_pending    = (fill_ptr != alloc_ptr);

    assign alloc_fire = rd_cmd_valid && rd_cmd_ready;
    assign fill_fire  = rd_data_valid && fill_pending;
    assign pop_fire   = get_return_data && has_return_data;

    ddr2_retbuf_ram #(
        .DATA_W (DATA_W),
        .ADX_W  (ADX_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk        (clk),
        .adx_we     (alloc_fire),
        .adx_waddr  (alloc_ptr[AW-1:0]),
        .adx_wdata  (rd_cmd_adx),
        .data_we    (fill_fire),
        .data_waddr (fill_ptr[AW-1:0]),
        .data_wdata (rd_data),
        .raddr      (rd_ptr[AW-1:0]),
        .radx       (slot_adx),
        .rdata      (slot_data)
    );

    // Advance the three ring pointers independently; any combination per cycle is legal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
        end else begin
            if (alloc_fire) alloc_ptr <= alloc_ptr + PTR_ONE;
            if (fill_fire)  fill_ptr  <= fill_ptr + PTR_ONE;
            if (pop_fire)   rd_ptr    <= rd_ptr + PTR_ONE;
        end
    end

    // Register the popped entry; outputs hold until the next successful pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            return_data <= '0;
            return_adx  <= '0;
        end else if (pop_fire) begin
            return_data <= slot_data;
            return_adx  <= slot_adx;
        end
    end

`ifdef DDR2_RETBUF_ERR_EN
    // Sticky protocol error capture: dropped data word and command issued while throttled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flags <= 2'b00;
        end else begin
            if (rd_data_valid && !fill_pending) err_flags[0] <= 1'b1;
            if (rd_cmd_valid && !rd_cmd_ready)  err_flags[1] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr2_read_return_buffer.sv
// Directed self-checking bench for ddr2_read_return_buffer: a per-cycle vector
// table for basic read/ordering/drop behaviour, then hand-written sequences for
// throttle, simultaneous events, wrap-around and asynchronous reset.
// With DDR2_RETBUF_ERR_EN defined, err_flags is also checked.
module tb_ddr2_read_return_buffer;
    import ddr2_pkg::*;

    localparam int DW = 128;
    localparam int AWD = 27;

    logic           clk = 1'b0;
    logic           reset;
    logic           rd_cmd_valid;
    logic [AWD-1:0] rd_cmd_adx;
    logic           rd_cmd_ready;
    logic           rd_data_valid;
    logic [DW-1:0]  rd_data;
    logic           has_return_data;
    logic           get_return_data;
    logic [DW-1:0]  return_data;
    logic [AWD-1:0] return_adx;
`ifdef DDR2_RETBUF_ERR_EN
    logic [1:0]     err_flags;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ddr2_read_return_buffer #(.DATA_W(DW), .ADX_W(AWD), .DEPTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .rd_cmd_valid    (rd_cmd_valid),
        .rd_cmd_adx      (rd_cmd_adx),
        .rd_cmd_ready    (rd_cmd_ready),
        .rd_data_valid   (rd_data_valid),
        .rd_data         (rd_data),
        .has_return_data (has_return_data),
        .get_return_data (get_return_data),
        .return_data     (return_data),
        .return_adx      (return_adx)
`ifdef DDR2_RETBUF_ERR_EN
        ,
        .err_flags       (err_flags)
`endif
    );

    typedef struct {
        logic           cv;
        logic [AWD-1:0] ca;
        logic           dv;
        logic [DW-1:0]  d;
        logic           g;
        logic           e_has;
        logic           e_rdy;
        ret_entry_t     e_ret;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [DW-1:0] dat(input int k);
        return {32'hC0FFEE00, 64'h0123_4567_89AB_CDEF, 32'(k)};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [AWD-1:0] ca, input logic dv,
                         input logic [DW-1:0] d, input logic g);
        rd_cmd_valid    = cv;
        rd_cmd_adx      = ca;
        rd_data_valid   = dv;
        rd_data         = d;
        get_return_data = g;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] d1, d2a, d2b, d2c, d4;

    initial begin
        d1  = 128'hDEADBEEF_00000000_00000000_00000001;
        d2a = 128'h11111111_22222222_33333333_44444444;
        d2b = 128'h55555555_66666666_77777777_88888888;
        d2c = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
        d4  = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
        //         cv   ca          dv   d     g     has   rdy   {ret adx, ret data}
        tbl[0]  = '{1'b1, 27'h100, 1'b0, '0,  1'b0, 1'b0, 1'b1, '{27'h0,   '0}};
        tbl[1]  = '{1'b0, 27'h0,   1'b0, '0,  1'b0, 1'b0, 1'b1, '{27'h0,   '0}};
        tbl[2]  = '{1'b0, 27'h0,   1'b1, d1,  1'b0, 1'b1, 1'b1, '{27'h0,   '0}};
        tbl[3]  = '{1'b0, 27'h0,   1'b0, '0,  1'b1, 1'b0, 1'b1, '{27'h100, d1}};
        tbl[4]  = '{1'b1, 27'h10,  1'b0, '0,  1'b0, 1'b0, 1'b1, '{27'h100, d1}};
        tbl[5]  = '{1'b1, 27'h20,  1'b0, '0,  1'b0, 1'b0, 1'b1, '{27'h100, d1}};
        tbl[6]  = '{1'b1, 27'h30,  1'b1, d2a, 1'b0, 1'b1, 1'b1, '{27'h100, d1}};
        tbl[7]  = '{1'b0, 27'h0,   1'b1, d2b, 1'b0, 1'b1, 1'b1, '{27'h100, d1}};
        tbl[8]  = '{1'b0, 27'h0,   1'b1, d2c, 1'b1, 1'b1, 1'b1, '{27'h10,  d2a}};
        tbl[9]  = '{1'b0, 27'h0,   1'b0, '0,  1'b1, 1'b1, 1'b1, '{27'h20,  d2b}};
        tbl[10] = '{1'b0, 27'h0,   1'b0, '0,  1'b1, 1'b0, 1'b1, '{27'h30,  d2c}};
        tbl[11] = '{1'b0, 27'h0,   1'b0, '0,  1'b1, 1'b0, 1'b1, '{27'h30,  d2c}};
        tbl[12] = '{1'b0, 27'h0,   1'b1, d4,  1'b0, 1'b0, 1'b1, '{27'h30,  d2c}};
        tbl[13] = '{1'b1, 27'h40,  1'b1, d1,  1'b0, 1'b0, 1'b1, '{27'h30,  d2c}};
        tbl[14] = '{1'b0, 27'h0,   1'b0, '0,  1'b0, 1'b0, 1'b1, '{27'h30,  d2c}};
        tbl[15] = '{1'b0, 27'h0,   1'b1, d4,  1'b0, 1'b1, 1'b1, '{27'h30,  d2c}};
        tbl[16] = '{1'b0, 27'h0,   1'b0, '0,  1'b1, 1'b0, 1'b1, '{27'h40,  d4}};

        // Reset state
        reset = 1'b1;
        idle();
        step();
        step();
        chk("rst_has", 128'(has_return_data), 128'(1'b0));
        chk("rst_rdy", 128'(rd_cmd_ready), 128'(1'b1));
        chk("rst_data", return_data, '0);
        chk("rst_adx", 128'(return_adx), '0);
        reset = 1'b0;

        // Table: single read, ordering, empty pop, stray/same-cycle drop
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].cv, tbl[i].ca, tbl[i].dv, tbl[i].d, tbl[i].g);
            step();
            chk($sformatf("v%0d_has", i), 128'(has_return_data), 128'(tbl[i].e_has));
            chk($sformatf("v%0d_rdy", i), 128'(rd_cmd_ready), 128'(tbl[i].e_rdy));
            chk($sformatf("v%0d_adx", i), 128'(return_adx), 128'(tbl[i].e_ret.adx));
            chk($sformatf("v%0d_data", i), return_data, tbl[i].e_ret.data);
        end
        idle();

        // Full throttle: 16 outstanding commands fill the buffer
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 27'(32'h200 + i), 1'b0, '0, 1'b0);
            step();
            chk($sformatf("thr_rdy%0d", i), 128'(rd_cmd_ready), 128'(i < 15));
        end
        drive(1'b1, 27'h300, 1'b0, '0, 1'b0);
        step();
        chk("thr_ignored_rdy", 128'(rd_cmd_ready), 128'(1'b0));
        chk("thr_ignored_has", 128'(has_return_data), 128'(1'b0));
        drive(1'b0, '0, 1'b1, dat(0), 1'b0);
        step();
        chk("thr_fill_has", 128'(has_return_data), 128'(1'b1));
        chk("thr_fill_rdy", 128'(rd_cmd_ready), 128'(1'b0));
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        chk("thr_pop_adx", 128'(return_adx), 128'(27'h200));
        chk("thr_pop_rdy", 128'(rd_cmd_ready), 128'(1'b1));
        drive(1'b1, 27'h210, 1'b0, '0, 1'b0);
        step();
        chk("thr_17_rdy", 128'(rd_cmd_ready), 128'(1'b0));
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, '0, 1'b1, dat(i), 1'b0);
            step();
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b1);
            step();
            chk($sformatf("thr_drain_adx%0d", i), 128'(return_adx), 128'(32'h200 + i));
            chk($sformatf("thr_drain_data%0d", i), return_data, dat(i));
        end
        idle();
        step();
        chk("thr_empty_has", 128'(has_return_data), 128'(1'b0));

        // Simultaneous allocate + fill + pop with 15 occupied
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 27'(32'h400 + i), 1'b0, '0, 1'b0);
            step();
        end
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, '0, 1'b1, dat(1000 + i), 1'b0);
            step();
        end
        chk("sim_pre_rdy", 128'(rd_cmd_ready), 128'(1'b1));
        drive(1'b1, 27'h40F, 1'b1, dat(1014), 1'b1);
        step();
        chk("sim_adx", 128'(return_adx), 128'(27'h400));
        chk("sim_data", return_data, dat(1000));
        chk("sim_rdy", 128'(rd_cmd_ready), 128'(1'b1));
        chk("sim_has", 128'(has_return_data), 128'(1'b1));
        drive(1'b1, 27'h410, 1'b0, '0, 1'b0);
        step();
        chk("sim_occ16_rdy", 128'(rd_cmd_ready), 128'(1'b0));
        for (int i = 15; i <= 16; i++) begin
            drive(1'b0, '0, 1'b1, dat(1000 + i), 1'b0);
            step();
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b1);
            step();
            chk($sformatf("sim_drain_adx%0d", i), 128'(return_adx), 128'(32'h400 + i));
            chk($sformatf("sim_drain_data%0d", i), return_data, dat(1000 + i));
        end
        idle();
        step();

        // Wrap: 40 command/data/pop triples
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 27'(32'h500 + i), 1'b0, '0, 1'b0);
            step();
            drive(1'b0, '0, 1'b1, dat(5000 + i), 1'b0);
            step();
            drive(1'b0, '0, 1'b0, '0, 1'b1);
            step();
            chk($sformatf("wrap_adx%0d", i), 128'(return_adx), 128'(32'h500 + i));
            chk($sformatf("wrap_data%0d", i), return_data, dat(5000 + i));
        end
        idle();
        step();
        chk("wrap_empty_has", 128'(has_return_data), 128'(1'b0));
        chk("wrap_rdy", 128'(rd_cmd_ready), 128'(1'b1));

`ifdef DDR2_RETBUF_ERR_EN
        chk("err_flags_set", 128'(err_flags), 128'(2'b11));
`endif

        // Asynchronous reset with 5 entries buffered
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 27'(32'h600 + i), 1'b0, '0, 1'b0);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, 1'b1, dat(2000 + i), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        chk("ar_pre_adx", 128'(return_adx), 128'(27'h600));
        chk("ar_pre_has", 128'(has_return_data), 128'(1'b1));
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_has", 128'(has_return_data), 128'(1'b0));
        chk("ar_rdy", 128'(rd_cmd_ready), 128'(1'b1));
        chk("ar_data", return_data, '0);
        chk("ar_adx", 128'(return_adx), '0);
`ifdef DDR2_RETBUF_ERR_EN
        chk("ar_err", 128'(err_flags), 128'(2'b00));
`endif
        step();
        reset = 1'b0;
        drive(1'b1, 27'h700, 1'b0, '0, 1'b0);
        step();
        idle();
        step();
        drive(1'b0, '0, 1'b1, dat(3000), 1'b0);
        step();
        chk("post_has", 128'(has_return_data), 128'(1'b1));
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        chk("post_adx", 128'(return_adx), 128'(27'h700));
        chk("post_data", return_data, dat(3000));
        chk("post_has_low", 128'(has_return_data), 128'(1'b0));
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
